multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: decodes the latched opcode into per-state datapath controls.
// Controls are combinational from state (plus mem_ready in FETCH); memory states stall until mem_ready.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_RWB      = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_IEXEC    = 4'd10;
    localparam logic [3:0] S_IWB      = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [3:0]  r_state;
    logic [31:0] r_retired;
    logic [3:0]  w_next_state;
    logic        w_retire;
    logic [3:0]  w_dec_state;
    logic        w_unused_funct;

    // funct is consumed by the external ALU control block only.
    assign w_unused_funct = ^funct;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      w_next_state = S_EXEC;
                    OP_LW, OP_SW:  w_next_state = S_MEMADR;
                    OP_BEQ:        w_next_state = S_BRANCH;
                    OP_J:          w_next_state = S_JUMP;
                    OP_ADDI:       w_next_state = S_IEXEC;
                    default:       w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: begin
                w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
                w_retire     = mem_ready;
            end
            S_EXEC:     w_next_state = S_RWB;
            S_IEXEC:    w_next_state = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_TRAP;
        endcase
    end

    // Decoding from FETCH while reset is high keeps outputs benign before the first edge.
    assign w_dec_state = reset ? S_FETCH : r_state;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_IWB:      reg_write = 1'b1;
            S_TRAP:     illegal = 1'b1;
            default: ;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: instruction-level model expands each instruction into its state path and queues per-cycle expectations.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] retired;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   st;
        logic mr;
    } step_t;

    typedef struct {
        logic        chk;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_retired = 32'd0;

    // Control vector order: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal.
    function automatic logic [16:0] ctrl_of(int st, logic mr);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb = 2'b00, op = 2'b00, ps = 2'b00;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, op, ps, ill};
    endfunction

    function automatic step_t mk(int st, logic mr);
        step_t s;
        s.st = st;
        s.mr = mr;
        return s;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
    endfunction

    task automatic drive_step(input step_t s, input logic in_rst, input logic [31:0] ret);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = in_rst;
        mem_ready = s.mr;
        funct     = 6'($urandom_range(0, 63));
        e.chk  = !in_rst;
        e.st   = 4'(s.st);
        e.ctrl = ctrl_of(in_rst ? 0 : s.st, s.mr);
        e.ret  = ret;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive_step(mk(0, rnd_bit()), 1'b1, 32'd0);
        end
        m_retired = 32'd0;
    endtask

    // cut > 0 truncates the instruction after that many cycles (caller then resets).
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                             input int trap_n, input int cut);
        step_t path[$];
        logic  retires = 1'b1;
        for (int i = 0; i < fs; i++) path.push_back(mk(0, 1'b0));
        path.push_back(mk(0, 1'b1));
        path.push_back(mk(1, rnd_bit()));
        case (op)
            6'h00: begin path.push_back(mk(6, rnd_bit())); path.push_back(mk(7, rnd_bit())); end
            6'h23: begin
                path.push_back(mk(2, rnd_bit()));
                for (int i = 0; i < ms; i++) path.push_back(mk(3, 1'b0));
                path.push_back(mk(3, 1'b1));
                path.push_back(mk(4, rnd_bit()));
            end
            6'h2B: begin
                path.push_back(mk(2, rnd_bit()));
                for (int i = 0; i < ms; i++) path.push_back(mk(5, 1'b0));
                path.push_back(mk(5, 1'b1));
            end
            6'h04: path.push_back(mk(8, rnd_bit()));
            6'h02: path.push_back(mk(9, rnd_bit()));
            6'h08: begin path.push_back(mk(10, rnd_bit())); path.push_back(mk(11, rnd_bit())); end
            default: begin
                retires = 1'b0;
                for (int i = 0; i < trap_n; i++) path.push_back(mk(12, rnd_bit()));
            end
        endcase
        if (cut > 0 && cut < path.size()) begin
            while (path.size() > cut) void'(path.pop_back());
            retires = 1'b0;
        end
        opcode = op;
        foreach (path[i]) drive_step(path[i], 1'b0, m_retired);
        if (retires) m_retired = m_retired + 32'd1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [16:0] got;
            e   = exp_q.pop_front();
            got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal};
            n_tests++;
            if (got !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl @%0t st=%0d: got %h want %h", $time, e.st, got, e.ctrl);
            end
            if (e.chk) begin
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state @%0t: got %0d want %0d", $time, state, e.st);
                end
                n_tests++;
                if (retired !== e.ret) begin
                    n_fail++;
                    $display("FAIL retired @%0t: got %0d want %0d", $time, retired, e.ret);
                end
            end
        end
    end

    initial begin
        logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        reset     = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b0;

        do_reset(2);
        run_instr(6'h00, 0, 0, 0, 0);
        run_instr(6'h23, 0, 3, 0, 0);
        run_instr(6'h2B, 0, 1, 0, 0);
        run_instr(6'h04, 0, 0, 0, 0);
        run_instr(6'h02, 0, 0, 0, 0);
        run_instr(6'h08, 1, 0, 0, 0);
        run_instr(6'h00, 2, 0, 0, 0);
        run_instr(6'h3F, 0, 0, 10, 0);
        do_reset(1);
        run_instr(6'h23, 0, 5, 0, 6);
        do_reset(1);
        run_instr(6'h00, 4, 0, 0, 2);
        do_reset(1);

        for (int k = 0; k < 150; k++) begin
            logic [5:0] op;
            int cut;
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            cut = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4), cut);
            if (cut > 0 || !is_legal(op)) do_reset($urandom_range(1, 2));
        end

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
